// File: rtl/logic_op_pkg.sv
// logic_op_pkg
//   Shared types and the bitwise operator evaluator for logic_op_pipe.
//   op_e      : 2-bit function select (AND, OR, XOR, NAND), applied bitwise
//   apply_op  : evaluates one op_e over 64-bit operands; callers size-cast
//               the result down to their own operand width.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  localparam int MAX_WIDTH  = 64;
  localparam int MAX_STAGES = 4;

  function automatic logic [MAX_WIDTH-1:0] apply_op(
    input op_e                  op,
    input logic [MAX_WIDTH-1:0] p,
    input logic [MAX_WIDTH-1:0] q
  );
    logic [MAX_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = p & q;
      OP_OR:   r = p | q;
      OP_XOR:  r = p ^ q;
      default: r = ~(p & q);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_stage.sv
// logic_op_stage
//   One pipeline slot holding {valid, x, y}.
//   clk, rst_n        : clock, asynchronous active-low reset
//   up_valid/up_x/up_y: slot contents offered by the upstream side
//   ready_in          : ready of the slot (or consumer) downstream of this one
//   valid, x, y       : registered slot contents
// The slot loads whenever it is empty or its contents are leaving this cycle.
module logic_op_stage
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_x,
  input  logic [WIDTH-1:0] up_y,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic             valid_reg;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic             load;

  assign load = !valid_reg || ready_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else if (load) begin
      valid_reg <= up_valid;
      // Data only moves with a real entry, so a bubble never disturbs x/y.
      if (up_valid) begin
        x_reg <= up_x;
        y_reg <= up_y;
      end
    end
  end

  assign valid = valid_reg;
  assign x     = x_reg;
  assign y     = y_reg;

endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe
//   Pipelined two-output bitwise logic cell: x = a op_x b, y = b op_y c.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake, operands sampled on accept
//   a, b, c, op_x, op_y  : operands and function selects (op_e encoding)
//   out_valid/out_ready  : downstream handshake at the last stage
//   x, y                 : results of the last stage
//   out_count            : delivered results, wrapping modulo 2^CNT_W
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       op_x,
  input  logic [1:0]       op_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] out_count
);

  if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_param
    $error("logic_op_pipe: illegal parameters WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  logic [WIDTH-1:0] x_comb;
  logic [WIDTH-1:0] y_comb;

  assign x_comb = WIDTH'(apply_op(op_e'(op_x), 64'(a), 64'(b)));
  assign y_comb = WIDTH'(apply_op(op_e'(op_y), 64'(b), 64'(c)));

  logic [STAGES-1:0] valid_vec;
  logic [STAGES:0]   ready_vec;
  logic [WIDTH-1:0]  x_s [STAGES];
  logic [WIDTH-1:0]  y_s [STAGES];

  // Ready chain evaluated in one block from the registered valid bits, so
  // the combinational path from out_ready to in_ready has no feedback.
  always_comb begin
    ready_vec         = '0;
    ready_vec[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready_vec[i] = !valid_vec[i] || ready_vec[i+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             up_valid;
      logic [WIDTH-1:0] up_x;
      logic [WIDTH-1:0] up_y;

      if (gi == 0) begin : g_head
        assign up_valid = in_valid;
        assign up_x     = x_comb;
        assign up_y     = y_comb;
      end else begin : g_body
        assign up_valid = valid_vec[gi-1];
        assign up_x     = x_s[gi-1];
        assign up_y     = y_s[gi-1];
      end

      logic_op_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (up_valid),
        .up_x     (up_x),
        .up_y     (up_y),
        .ready_in (ready_vec[gi+1]),
        .valid    (valid_vec[gi]),
        .x        (x_s[gi]),
        .y        (y_s[gi])
      );
    end
  endgenerate

  assign in_ready  = ready_vec[0];
  assign out_valid = valid_vec[STAGES-1];
  assign x         = x_s[STAGES-1];
  assign y         = y_s[STAGES-1];

  logic [CNT_W-1:0] out_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count_reg <= '0;
    end else if (out_valid && out_ready) begin
      out_count_reg <= out_count_reg + CNT_W'(1);
    end
  end

  assign out_count = out_count_reg;

endmodule

// File: tb/tb_logic_op_pipe.sv
module tb_logic_op_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, c = '0;
  logic [1:0]       op_x = '0, op_y = '0;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] x, y;
  logic [CNT_W-1:0] out_count;

  logic_op_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .op_x(op_x), .op_y(op_y),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bitwise op defined directly by its truth rule.
  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                               input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] r;
    for (int k = 0; k < WIDTH; k++) begin
      case (op)
        2'd0: r[k] = p[k] && q[k];
        2'd1: r[k] = p[k] || q[k];
        2'd2: r[k] = p[k] != q[k];
        default: r[k] = !(p[k] && q[k]);
      endcase
    end
    return r;
  endfunction

  typedef struct { logic [WIDTH-1:0] ex; logic [WIDTH-1:0] ey; } res_t;
  res_t q[$];
  int   mcnt = 0;

  // Scoreboard: sampled mid-cycle, applies the handshakes of the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(out_ready || q.size() < STAGES));
      check("out_count", 64'(out_count), 64'(mcnt % (1 << CNT_W)));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious out_valid", 64'(out_valid), 64'(0));
        end else begin
          check("x", 64'(x), 64'(q[0].ex));
          check("y", 64'(y), 64'(q[0].ey));
          if (out_ready) begin
            $display("[TB] deliver #%0d x=%h y=%h", mcnt + 1, x, y);
            void'(q.pop_front());
            mcnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{ex: ref_op(op_x, a, b), ey: ref_op(op_y, b, c)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ox, input logic [1:0] oy,
                       input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic [WIDTH-1:0] cc);
    in_valid = v; op_x = ox; op_y = oy; a = aa; b = bb; c = cc;
  endtask

  task automatic drive_rand();
    drive(1'b1, 2'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(name, 64'(q.size()), 64'(0));
  endtask

  typedef struct { logic [1:0] op; logic [WIDTH-1:0] ex; logic [WIDTH-1:0] ey; } vec_t;
  vec_t tbl [4];

  initial begin
    int hi_cnt, first_hi, last_hi, cnt0, n;
    logic [WIDTH-1:0] hx, hy;

    tbl[0] = '{op: 2'd0, ex: 8'hC0, ey: 8'h88};
    tbl[1] = '{op: 2'd1, ex: 8'hFC, ey: 8'hEE};
    tbl[2] = '{op: 2'd2, ex: 8'h3C, ey: 8'h66};
    tbl[3] = '{op: 2'd3, ex: 8'h3F, ey: 8'h77};

    // 1: reset then idle
    do_reset();
    check("rst out_valid", 64'(out_valid), 64'(0));
    check("rst x", 64'(x), 64'(0));
    check("rst y", 64'(y), 64'(0));
    check("rst out_count", 64'(out_count), 64'(0));
    check("rst in_ready", 64'(in_ready), 64'(1));

    // 2: truth table with exact latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].op, 8'hF0, 8'hCC, 8'hAA);
      check("tt in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      check("tt latency-1 out_valid", 64'(out_valid), 64'(0));
      tick();
      check("tt latency out_valid", 64'(out_valid), 64'(1));
      check("tt x", 64'(x), 64'(tbl[i].ex));
      check("tt y", 64'(y), 64'(tbl[i].ey));
      tick();
    end

    // 3: ten back-to-back transactions
    do_reset();
    out_ready = 1'b1;
    hi_cnt = 0; first_hi = -1; last_hi = -1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc < 10) drive_rand(); else in_valid = 1'b0;
      tick();
      if (out_valid) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = cyc;
        last_hi = cyc;
      end
    end
    check("b2b valid cycles", 64'(hi_cnt), 64'(10));
    check("b2b first valid", 64'(first_hi), 64'(1));
    check("b2b contiguous", 64'(last_hi - first_hi + 1), 64'(10));
    check("b2b out_count", 64'(out_count), 64'(10));

    // 4: backpressure fills the pipe, third transaction waits at the input
    cnt0 = mcnt;
    out_ready = 1'b0;
    drive_rand();
    tick();
    check("bp in_ready after 1", 64'(in_ready), 64'(1));
    drive_rand();
    tick();
    check("bp in_ready after 2", 64'(in_ready), 64'(0));
    drive_rand();
    hx = x; hy = y;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp hold in_ready", 64'(in_ready), 64'(0));
      check("bp hold out_valid", 64'(out_valid), 64'(1));
      check("bp hold x", 64'(x), 64'(hx));
      check("bp hold y", 64'(y), 64'(hy));
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("bp drain");
    check("bp delivered", 64'(mcnt - cnt0), 64'(3));

    // 5: asynchronous reset with two entries in flight
    out_ready = 1'b0;
    drive_rand();
    tick();
    drive_rand();
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(out_valid), 64'(0));
    check("async rst out_count", 64'(out_count), 64'(0));
    check("async rst in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post rst no stale", 64'(out_valid), 64'(0));
    end

    // 6: counter wrap at 2^CNT_W
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      drive_rand();
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
      check("wrap out_valid seen", 64'(out_valid), 64'(1));
      tick();
      if (k >= 15) check("wrap out_count", 64'(out_count), 64'(k % 16));
    end

    // Random traffic with random backpressure against the scoreboard
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(0, 3) != 0) drive_rand(); else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain("rand drain");
    tick();
    check("final out_valid", 64'(out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Parametrised, pipelined successor to the lab's two-output AND/OR combinational cell.
- Each accepted transaction carries operands a, b, c and two op selects.
- Computes x = a op_x b and y = b op_y c over WIDTH bits.
- Results travel through STAGES registered stages with valid/ready backpressure; a wrapping counter tallies delivered results for bench scoreboarding.

Parameters:
- WIDTH, 8, operand/result bit width (1..64)
- STAGES, 2, pipeline depth in registered stages (1..4)
- CNT_W, 16, width of delivered-result counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream transaction present
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c  input  WIDTH  operand C
- op_x  input  2  function for x (logic_op_pkg::op_e)
- op_y  input  2  function for y (logic_op_pkg::op_e)
- out_valid  output  1  result present at last stage
- out_ready  input  1  downstream accepts result
- x  output  WIDTH  a op_x b
- y  output  WIDTH  b op_y c
- out_count  output  CNT_W  number of results delivered, mod 2^CNT_W

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Op encoding (op_e), applied bitwise:
  - 00 OP_AND
  - 01 OP_OR
  - 10 OP_XOR
  - 11 OP_NAND
- Function is evaluated combinationally on input; the result is registered into stage 0.
- Later stages carry only {valid, x, y}.
- Handshake:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - Operands and ops are sampled only on accept.
- Stage advance rule, for stage i with last stage S = STAGES-1:
  - ready_i = !valid_i || ready_{i+1}; ready_S = !valid_S || out_ready.
  - in_ready = ready_0, a purely combinational ready chain. No skid buffer.
  - On ready_i, stage i loads stage i-1 (or the input), and its valid takes the upstream valid/accept.
- Latency: exactly STAGES cycles from accept edge to out_valid high, with out_ready held 1.
- Throughput: 1 result per cycle with no stall.
- Stall:
  - With out_ready=0, out_valid, x and y hold stable until delivery.
  - The pipe fills to STAGES entries, then in_ready=0.
  - No transaction is lost or duplicated.
  - Order is preserved.
- Bubbles: when in_valid=0, empty slots advance and collapse. A held result is never overwritten.
- Counter:
  - out_count increments by 1 on each delivery.
  - Wraps from 2^CNT_W-1 to 0.
- Reset:
  - Reset values: all valid bits 0, x=0, y=0, out_count=0, out_valid=0. in_ready=1 after reset.
  - Async assert mid-operation discards all in-flight entries immediately, without waiting for a clock edge.
  - Deassert is synchronised by the integrator; the block needs no internal synchroniser.
- Simultaneous accept and deliver with a full pipe: allowed in the same cycle. The pipe stays full and the counter increments.
- Illegal parameter values (STAGES<1 or >4, WIDTH<1) are flagged by an elaboration-time $error.

Decomposition:
- Package logic_op_pkg:
  - typedef enum logic [1:0] op_e {OP_AND, OP_OR, OP_XOR, OP_NAND}
  - function apply_op(op_e, logic [63:0], logic [63:0]), result truncated to WIDTH
- Sub-module logic_op_stage:
  - Parametrised by WIDTH.
  - One register slot {valid, x, y} with ready_in/ready_out logic.
  - Instantiated STAGES times by a generate loop in logic_op_pipe.
- Top-level logic: op evaluation, stage chaining, out_count.

Test Plan:
1. Reset then idle: rst_n=0 for 3 cycles, release → out_valid=0, x=y=0, out_count=0, in_ready=1.
2. Truth table (WIDTH=8, STAGES=2): a=8'hF0, b=8'hCC, c=8'hAA, sweep op_x/op_y over all 4 values with out_ready=1.
   - Exactly 2 cycles after each accept, expect x=C0/FC/3C/3F and y=88/EE/66/77.
3. Back-to-back 10 transactions, out_ready=1 → out_valid continuous for 10 cycles, results in order, out_count=10.
4. Backpressure: out_ready=0 while sending 3 transactions with STAGES=2.
   - Expect in_ready=0 after 2 accepts; 3rd held at input; x/y stable.
   - Then raise out_ready → 3 results in order, no loss.
5. Mid-flight reset: accept 2 transactions, assert rst_n=0 between clock edges → out_valid drops to 0 immediately, out_count=0, no stale result after release.
6. Counter wrap (CNT_W=4): deliver 17 results → out_count reads 15 then 0 then 1.
